// File: rtl/alu_regfile_core.sv
// alu_regfile_core: 4x8 register file, 6502-style binary/BCD ALU and result/flag latch
module alu_regfile_core #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4
) (
    input  logic             ph2,
    input  logic             reset,
    input  logic [1:0]       reg_read_addr_a,
    input  logic [1:0]       reg_read_addr_b,
    input  logic [1:0]       reg_write_addr,
    input  logic             reg_write_en,
    input  logic             a_sel,
    input  logic [WIDTH-1:0] a_ext,
    input  logic             b_sel,
    input  logic [WIDTH-1:0] b_ext,
    input  logic [3:0]       alu_op,
    input  logic             c_in,
    input  logic             bcd,
    output logic [WIDTH-1:0] reg_a_out,
    output logic [WIDTH-1:0] reg_b_out,
    output logic [WIDTH-1:0] r_out,
    output logic [WIDTH-1:0] flags_out
);
    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH-1:0] a, b, bx, y, bcd_add, bcd_sub;
    logic [WIDTH:0]   sum9;
    logic [4:0]       lo5, hi5;
    logic [3:0]       lo_fix, hi_fix;
    logic             v_add, lc, dc, lb, c, v, n;

    assign reg_a_out = regs[reg_read_addr_a];
    assign reg_b_out = regs[reg_read_addr_b];
    assign a  = a_sel ? a_ext : reg_a_out;
    assign b  = b_sel ? b_ext : reg_b_out;
    assign bx = (alu_op == 4'd1) ? ~b : b;
    assign sum9  = {1'b0, a} + {1'b0, bx} + {8'b0, c_in};
    assign v_add = (a[7] == bx[7]) && (sum9[7] != a[7]);
    assign lo5    = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, c_in};
    assign lc     = lo5 > 5'd9;
    assign lo_fix = lo5[3:0] + (lc ? 4'd6 : 4'd0);
    assign hi5    = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'b0, lc};
    assign dc     = hi5 > 5'd9;
    assign hi_fix = hi5[3:0] + (dc ? 4'd6 : 4'd0);
    assign bcd_add = {hi_fix, lo_fix};
    assign lb      = {1'b0, a[3:0]} < ({1'b0, b[3:0]} + {4'b0, ~c_in});
    assign bcd_sub = {sum9[7:4], sum9[3:0] - (lb ? 4'd6 : 4'd0)} - (sum9[8] ? 8'h00 : 8'h60);

    always_comb begin
        y = a;
        c = c_in;
        v = 1'b0;
        case (alu_op)
            4'd0: begin y = bcd ? bcd_add : sum9[7:0]; c = bcd ? dc : sum9[8]; v = v_add; end
            4'd1: begin y = bcd ? bcd_sub : sum9[7:0]; c = sum9[8]; v = v_add; end
            4'd2: y = a & b;
            4'd3: y = a | b;
            4'd4: y = a ^ b;
            4'd5: begin y = {a[6:0], 1'b0}; c = a[7]; end
            4'd6: begin y = {1'b0, a[7:1]}; c = a[0]; end
            4'd7: begin y = {a[6:0], c_in}; c = a[7]; end
            4'd8: begin y = {c_in, a[7:1]}; c = a[0]; end
            4'd10: y = b;
            4'd11: y = a + 8'd1;
            4'd12: y = a - 8'd1;
            4'd13: begin y = a & b; v = b[6]; end
            default: y = a;
        endcase
        n = (alu_op == 4'd13) ? b[7] : y[7];
    end

    always_ff @(posedge ph2) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            r_out     <= '0;
            flags_out <= '0;
        end else begin
            if (reg_write_en) regs[reg_write_addr] <= r_out;
            r_out     <= y;
            flags_out <= {n, v, 4'b0, y == 8'h00, c};
        end
    end
endmodule

// File: tb/tb_alu_regfile_core.sv
// tb_alu_regfile_core: directed vectors with hand-computed results for alu_regfile_core
module tb_alu_regfile_core;
    logic       ph2 = 0, reset = 1;
    logic [1:0] reg_read_addr_a = 0, reg_read_addr_b = 0, reg_write_addr = 0;
    logic       reg_write_en = 0, a_sel = 1, b_sel = 1, c_in = 0, bcd = 0;
    logic [7:0] a_ext = 0, b_ext = 0;
    logic [3:0] alu_op = 0;
    logic [7:0] reg_a_out, reg_b_out, r_out, flags_out;
    int vectors = 0, errs = 0;

    alu_regfile_core dut (
        .ph2(ph2), .reset(reset),
        .reg_read_addr_a(reg_read_addr_a), .reg_read_addr_b(reg_read_addr_b),
        .reg_write_addr(reg_write_addr), .reg_write_en(reg_write_en),
        .a_sel(a_sel), .a_ext(a_ext), .b_sel(b_sel), .b_ext(b_ext),
        .alu_op(alu_op), .c_in(c_in), .bcd(bcd),
        .reg_a_out(reg_a_out), .reg_b_out(reg_b_out),
        .r_out(r_out), .flags_out(flags_out)
    );

    always #5 ph2 = ~ph2;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ph2);
        #1;
    endtask

    task automatic alu(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                       input logic ci, input logic d);
        a_sel = 1; b_sel = 1; a_ext = a; b_ext = b; alu_op = op; c_in = ci; bcd = d;
        tick();
    endtask

    task automatic expect_rf(input string tag, input logic [7:0] r, input logic [7:0] f);
        chk({tag, " r"}, r_out, r);
        chk({tag, " f"}, flags_out, f);
    endtask

    initial begin
        tick();
        reset = 0;
        reg_read_addr_a = 0; reg_read_addr_b = 3; #1;
        chk("rst rega", reg_a_out, 8'h00);
        chk("rst regb", reg_b_out, 8'h00);
        expect_rf("rst", 8'h00, 8'h00);

        alu(8'h50, 8'h50, 4'd0, 0, 0);  expect_rf("add", 8'hA0, 8'hC0);
        reg_write_en = 1; reg_write_addr = 2; reg_read_addr_a = 2;
        a_ext = 8'h33; alu_op = 4'd9; #1;
        chk("wb before", reg_a_out, 8'h00);
        tick();
        reg_write_en = 0;
        chk("wb after", reg_a_out, 8'hA0);
        expect_rf("pass a", 8'h33, 8'h00);
        a_sel = 0; b_sel = 1; b_ext = 8'h01; alu_op = 4'd0; c_in = 0; bcd = 0;
        tick();
        expect_rf("add reg", 8'hA1, 8'h80);

        alu(8'h10, 8'h10, 4'd1, 1, 0);  expect_rf("sub eq", 8'h00, 8'h03);
        alu(8'h00, 8'h01, 4'd1, 1, 0);  expect_rf("sub lt", 8'hFF, 8'h80);
        alu(8'h19, 8'h28, 4'd0, 0, 1);  expect_rf("bcd add", 8'h47, 8'h00);
        alu(8'h99, 8'h01, 4'd0, 0, 1);  expect_rf("bcd wrap", 8'h00, 8'h03);
        alu(8'h42, 8'h13, 4'd1, 1, 1);  expect_rf("bcd sub", 8'h29, 8'h01);
        alu(8'h01, 8'h00, 4'd8, 1, 0);  expect_rf("ror", 8'h80, 8'h81);
        alu(8'h80, 8'h00, 4'd5, 0, 0);  expect_rf("asl", 8'h00, 8'h03);
        alu(8'h0F, 8'hC0, 4'd13, 0, 0); expect_rf("bit c0", 8'h00, 8'hC2);
        alu(8'h0F, 8'hC0, 4'd13, 1, 0); expect_rf("bit c1", 8'h00, 8'hC3);
        alu(8'hF0, 8'h3C, 4'd2, 1, 1);  expect_rf("and", 8'h30, 8'h01);
        alu(8'hF0, 8'h0C, 4'd3, 0, 0);  expect_rf("or", 8'hFC, 8'h80);
        alu(8'hFF, 8'hFF, 4'd4, 0, 0);  expect_rf("xor", 8'h00, 8'h02);
        alu(8'h01, 8'h00, 4'd6, 0, 0);  expect_rf("lsr", 8'h00, 8'h03);
        alu(8'h80, 8'h00, 4'd7, 1, 0);  expect_rf("rol", 8'h01, 8'h01);
        alu(8'hFF, 8'h00, 4'd11, 0, 0); expect_rf("inc", 8'h00, 8'h02);
        alu(8'h00, 8'h00, 4'd12, 1, 0); expect_rf("dec", 8'hFF, 8'h81);
        alu(8'h00, 8'h7F, 4'd10, 0, 0); expect_rf("pass b", 8'h7F, 8'h00);
        alu(8'h80, 8'h00, 4'd15, 0, 0); expect_rf("op15", 8'h80, 8'h80);

        reset = 1; reg_write_en = 1; reg_write_addr = 1;
        alu(8'h55, 8'h00, 4'd9, 0, 0);
        reset = 0; reg_write_en = 0;
        reg_read_addr_a = 1; reg_read_addr_b = 2; #1;
        chk("rst wr reg1", reg_a_out, 8'h00);
        chk("rst reg2", reg_b_out, 8'h00);
        expect_rf("rst mid", 8'h00, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
